alu_load_ctrl: RTL and testbench
================================

ALU_LOAD_CTRL -- requirements
Module: alu_load_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, operand and result width.
REQ-002 SHALL have parameter OP_WIDTH, default 6, opcode width.
REQ-003 SHALL have parameter PUL_WIDTH, default 3, button count (bit0 = A, bit1 = B, bit2 = OP).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-cycle count used only when debounce is compiled in.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port i_switches, input, BUS_WIDTH bits, operand/opcode source.
REQ-008 SHALL have port i_pulsador, input, PUL_WIDTH bits, raw asynchronous buttons, active-high.
REQ-009 SHALL have port i_alu_result, input, BUS_WIDTH bits, combinational result from the ALU.
REQ-010 SHALL have ports o_data_a / o_data_b, output, BUS_WIDTH bits each, latched operands to the ALU.
REQ-011 SHALL have port o_op, output, OP_WIDTH bits, latched opcode to the ALU.
REQ-012 SHALL have port o_result, output, BUS_WIDTH bits, captured ALU result.
REQ-013 SHALL have port o_valid, output, 1 bit, high while o_result holds a result for the current operand set.
REQ-014 SHALL have port o_state, output, 3 bits, current FSM state encoding for debug/LEDs.

Function
REQ-015 Each i_pulsador bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle pulse per press.
REQ-016 Without debounce, the register targeted by a press SHALL update on the 3rd rising clk edge after the raw button rises; holding a button SHALL produce exactly one pulse.
REQ-017 FSM states SHALL be LOAD_A(0), LOAD_B(1), LOAD_OP(2), EXEC(3), SHOW(4).
REQ-018 LOAD_A: on pulse0, o_data_a <= i_switches, clear o_valid, go LOAD_B.
REQ-019 LOAD_B: on pulse1, o_data_b <= i_switches, go LOAD_OP.
REQ-020 LOAD_OP: on pulse2, o_op <= i_switches[OP_WIDTH-1:0], go EXEC.
REQ-021 EXEC SHALL last exactly one cycle, capture i_alu_result into o_result, set o_valid, go SHOW.
REQ-022 SHOW SHALL hold o_result/o_valid; pulse0 SHALL behave as in LOAD_A, i.e. start a new sequence.
REQ-023 Pulse0 in LOAD_B or LOAD_OP SHALL reload o_data_a and go LOAD_B (restart); other out-of-order pulses SHALL be ignored.
REQ-024 Simultaneous pulses SHALL be resolved by accepting only the pulse expected by the current state, with pulse0 taking precedence per REQ-023.
REQ-025 The opcode SHALL be passed through unchecked; undefined opcodes yield whatever the ALU returns.
REQ-026 Operand and result registers SHALL change only in the states named above.

Reset
REQ-027 On reset low, all outputs SHALL be zero, the FSM SHALL be LOAD_A, and the synchronizers, edge detectors and debounce counters SHALL clear, immediately and regardless of clk.
REQ-028 A reset asserted mid-sequence SHALL discard any partial load; buttons held across reset release SHALL NOT generate a pulse.

Configuration
REQ-029 Macro ALU_LOAD_CTRL_DEBOUNCE_EN defined: each synchronized button SHALL be stable for DEBOUNCE_CYCLES consecutive cycles before its filtered level changes; edges are detected on the filtered level, adding DEBOUNCE_CYCLES cycles of latency.
REQ-030 Macro undefined: no debounce counters are built; timing is per REQ-016.

Structure
REQ-031 Package alu_ctrl_pkg SHALL hold the state encodings, button index constants, and ALU opcode constants (e.g. ADD = 6'b100000).
REQ-032 Sub-module btn_edge_sync (synchronizer, optional debounce, edge detect) SHALL be instantiated once per button.

Verification
REQ-033 Bench SHALL check: reset low -> all outputs 0, o_state = 0.
REQ-034 Bench SHALL check: switches 0x0004 + btn0, 0x000F + btn1, 0x0020 + btn2 -> o_data_a = 0x0004, o_data_b = 0x000F, o_op = 0x20, o_result = 0x0013, o_valid = 1, o_state = 4.
REQ-035 Bench SHALL check: btn1 pressed in LOAD_A -> no register change, state stays 0.
REQ-036 Bench SHALL check: btn0 with 0x0007 in LOAD_OP -> o_data_a = 0x0007, state = 1, o_data_b unchanged.
REQ-037 Bench SHALL check: btn2 held 50 cycles -> exactly one EXEC cycle.
REQ-038 Bench SHALL check: reset pulsed in LOAD_OP -> outputs 0, state 0; with debounce EN, a 3-cycle glitch on btn0 -> no load.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operand-load controller.
//   state_e      : FSM state encoding, also driven out on o_state
//   BTN_*        : bit index of each button within i_pulsador
//   OP_*         : ALU opcode constants (MIPS-style funct codes)
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/btn_edge_sync.sv
// One button conditioner: 2-flop synchronizer, optional debounce filter,
// rising-edge detector producing a single-cycle pulse per press.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   i_btn    : raw asynchronous button, active-high
//   o_pulse  : one-cycle pulse on each accepted press
// Macro ALU_LOAD_CTRL_DEBOUNCE_EN: when defined, the synchronized level must
// hold for DEBOUNCE_CYCLES consecutive cycles before the filtered level moves.
module btn_edge_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("btn_edge_sync: DEBOUNCE_CYCLES must be at least 1");
  end

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       lvl;
  logic       lvl_prev_q, lvl_prev_d;

  // fill_q marks when the synchronizer holds real samples instead of reset
  // zeros. Edges are only honoured once the button has been observed low, so
  // a button held through reset release never produces a pulse.
  always_comb begin
    sync1_d    = i_btn;
    sync2_d    = sync1_q;
    fill_d     = {fill_q[0], 1'b1};
    armed_d    = armed_q | (fill_q[1] & ~sync2_q);
    lvl_prev_d = lvl;
    o_pulse    = armed_q & lvl & ~lvl_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      fill_q     <= '0;
      armed_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      lvl_prev_q <= lvl_prev_d;
    end
  end

`ifdef ALU_LOAD_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          flt_q, flt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs while the synchronized level disagrees with the filtered
  // level; any agreement restarts it.
  always_comb begin
    flt_d = flt_q;
    cnt_d = '0;
    if (sync2_q != flt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        flt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = sync2_q;
`endif

endmodule

// File: rtl/alu_load_ctrl.sv
// Operand/opcode loader for a switch-and-button ALU front panel.
// Button A loads operand A, B loads operand B, OP loads the opcode and
// triggers a one-cycle EXEC that captures the external ALU result.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   i_switches   : operand / opcode source
//   i_pulsador   : raw buttons (bit0 = A, bit1 = B, bit2 = OP), active-high
//   i_alu_result : combinational ALU result for o_data_a/o_data_b/o_op
//   o_data_a/b   : latched operands
//   o_op         : latched opcode (passed through unchecked)
//   o_result     : captured ALU result
//   o_valid      : o_result belongs to the current operand set
//   o_state      : FSM state encoding for debug/LEDs
// Macro ALU_LOAD_CTRL_DEBOUNCE_EN: enables per-button debounce filtering.
module alu_load_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH       = 16,
  parameter int unsigned OP_WIDTH        = 6,
  parameter int unsigned PUL_WIDTH       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] i_switches,
  input  logic [PUL_WIDTH-1:0] i_pulsador,
  input  logic [BUS_WIDTH-1:0] i_alu_result,
  output logic [BUS_WIDTH-1:0] o_data_a,
  output logic [BUS_WIDTH-1:0] o_data_b,
  output logic [OP_WIDTH-1:0]  o_op,
  output logic [BUS_WIDTH-1:0] o_result,
  output logic                 o_valid,
  output logic [2:0]           o_state
);

  logic [PUL_WIDTH-1:0] pulse;

  for (genvar gi = 0; gi < PUL_WIDTH; gi++) begin : g_btn
    btn_edge_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (i_pulsador[gi]),
      .o_pulse(pulse[gi])
    );
  end

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] data_a_q, data_a_d;
  logic [BUS_WIDTH-1:0] data_b_q, data_b_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic                 valid_q, valid_d;

  // A-press outside EXEC always (re)starts a sequence and wins over any
  // simultaneous press; otherwise only the press the state expects counts.
  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_EXEC: begin
        result_d = i_alu_result;
        valid_d  = 1'b1;
        state_d  = ST_SHOW;
      end
      default: begin
        if (pulse[BTN_A]) begin
          data_a_d = i_switches;
          valid_d  = 1'b0;
          state_d  = ST_LOAD_B;
        end else if (state_q == ST_LOAD_B && pulse[BTN_B]) begin
          data_b_d = i_switches;
          state_d  = ST_LOAD_OP;
        end else if (state_q == ST_LOAD_OP && pulse[BTN_OP]) begin
          op_d     = i_switches[OP_WIDTH-1:0];
          state_d  = ST_EXEC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD_A;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_op     = op_q;
  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_alu_load_ctrl.sv
module tb_alu_load_ctrl;
  import alu_ctrl_pkg::*;

  localparam int BW = 16;
  localparam int OW = 6;
  localparam int PW = 3;
  localparam int DB = 16;
`ifdef ALU_LOAD_CTRL_DEBOUNCE_EN
  localparam int HOLD_BASE = DB + 3;
  localparam int SETTLE    = DB + 6;
`else
  localparam int HOLD_BASE = 1;
  localparam int SETTLE    = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] sw;
  logic [PW-1:0] pul;
  logic [BW-1:0] alu_res;
  logic [BW-1:0] o_data_a, o_data_b, o_result;
  logic [OW-1:0] o_op;
  logic          o_valid;
  logic [2:0]    o_state;

  always #5 clk = ~clk;

  alu_load_ctrl #(
    .BUS_WIDTH      (BW),
    .OP_WIDTH       (OW),
    .PUL_WIDTH      (PW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_switches  (sw),
    .i_pulsador  (pul),
    .i_alu_result(alu_res),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .o_result    (o_result),
    .o_valid     (o_valid),
    .o_state     (o_state)
  );

  // External ALU seen by the DUT (also used by the reference model).
  function automatic logic [BW-1:0] alu_f(input logic [BW-1:0] a, b, input logic [OW-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return BW'($signed(a) >>> b[3:0]);
      OP_SRL:  return a >> b[3:0];
      default: return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
    endcase
  endfunction

  always_comb alu_res = alu_f(o_data_a, o_data_b, o_op);

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [OW-1:0] op;
    logic [BW-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exec_cnt = 0;

  // Reference model: panel contents and phase (0=A,1=B,2=OP,4=SHOW).
  logic [BW-1:0] m_a, m_b, m_res;
  logic [OW-1:0] m_op;
  logic          m_valid;
  int            m_st;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0; m_st = 0;
  endfunction

  function automatic void model_apply(input logic [2:0] m, input logic [BW-1:0] s);
    if (m[0]) begin
      m_a = s; m_valid = 1'b0; m_st = 1;
    end else if (m_st == 1 && m[1]) begin
      m_b = s; m_st = 2;
    end else if (m_st == 2 && m[2]) begin
      m_op    = s[OW-1:0];
      m_res   = alu_f(m_a, m_b, m_op);
      m_valid = 1'b1;
      m_st    = 4;
      sb.push_back('{a: m_a, b: m_b, op: m_op, r: m_res});
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_a"},     32'(o_data_a), 32'(m_a));
    check({tag, "_b"},     32'(o_data_b), 32'(m_b));
    check({tag, "_op"},    32'(o_op),     32'(m_op));
    check({tag, "_res"},   32'(o_result), 32'(m_res));
    check({tag, "_valid"}, 32'(o_valid),  32'(m_valid));
    check({tag, "_state"}, 32'(o_state),  32'(m_st));
  endtask

  task automatic press(input logic [2:0] m, input logic [BW-1:0] s, input int hold);
    model_apply(m, s);
    @(negedge clk);
    sw  = s;
    pul = m;
    repeat (HOLD_BASE + hold) @(negedge clk);
    pul = '0;
    repeat (SETTLE) @(negedge clk);
  endtask

  // Monitor: every fresh o_valid is matched against the next expected result.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_v = 1'b0;
      end else begin
        if (o_state == 3'd3) exec_cnt++;
        if (o_valid && !prev_v) begin
          check("sb_entry_present", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_a",   32'(o_data_a), 32'(e.a));
            check("sb_b",   32'(o_data_b), 32'(e.b));
            check("sb_op",  32'(o_op),     32'(e.op));
            check("sb_res", 32'(o_result), 32'(e.r));
          end
        end
        prev_v = o_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] ops [8];
    int            e0;
    logic [2:0]    m;
    logic [BW-1:0] s;
    int            r, want;

    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
    ops[4] = OP_XOR; ops[5] = OP_NOR; ops[6] = OP_SRA; ops[7] = OP_SRL;

    reset = 1'b0; sw = '0; pul = '0;
    model_reset();
    #3;
    check_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // B pressed in LOAD_A is ignored
    press(3'b010, 16'h1234, 1);
    check_outputs("ignore_b");

`ifdef ALU_LOAD_CTRL_DEBOUNCE_EN
    // short glitch on A is filtered out
    @(negedge clk);
    sw = 16'hABCD; pul = 3'b001;
    repeat (3) @(negedge clk);
    pul = '0;
    repeat (SETTLE) @(negedge clk);
    check_outputs("glitch");
    press(3'b001, 16'h0004, 0);
`else
    // latency: update lands on the 3rd rising edge after the press
    model_apply(3'b001, 16'h0004);
    @(negedge clk);
    sw = 16'h0004; pul = 3'b001;
    @(posedge clk); @(posedge clk); #1;
    check("lat_edge2_state", 32'(o_state), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_state", 32'(o_state), 32'd1);
    check("lat_edge3_a", 32'(o_data_a), 32'h0004);
    @(negedge clk);
    pul = '0;
    repeat (SETTLE) @(negedge clk);
`endif
    press(3'b010, 16'h000F, 1);
    press(3'b100, 16'h0020, 1);
    check("basic_a",     32'(o_data_a), 32'h0004);
    check("basic_b",     32'(o_data_b), 32'h000F);
    check("basic_op",    32'(o_op),     32'h20);
    check("basic_res",   32'(o_result), 32'h0013);
    check("basic_valid", 32'(o_valid),  32'd1);
    check("basic_state", 32'(o_state),  32'd4);
    check_outputs("basic");

    // A pressed in LOAD_OP restarts with new operand A
    press(3'b001, 16'h0011, 1);
    press(3'b010, 16'h0022, 1);
    press(3'b001, 16'h0007, 1);
    check("restart_a",     32'(o_data_a), 32'h0007);
    check("restart_b",     32'(o_data_b), 32'h0022);
    check("restart_state", 32'(o_state),  32'd1);
    check_outputs("restart");

    // OP held for 50 cycles executes exactly once
    press(3'b010, 16'h0003, 1);
    e0 = exec_cnt;
    press(3'b100, 16'h0020, 50);
    check("held_exec_count", 32'(exec_cnt - e0), 32'd1);
    check_outputs("held");

    // reset in LOAD_OP, with A held across release
    press(3'b001, 16'h0101, 1);
    press(3'b010, 16'h0202, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    pul   = 3'b001;
    sw    = 16'h0BAD;
    model_reset();
    #1;
    check_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (SETTLE + 6) @(negedge clk);
    check_outputs("held_over_reset");
    pul = '0;
    repeat (SETTLE) @(negedge clk);
    check_outputs("after_release");

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      r    = $urandom_range(0, 9);
      want = (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0;
      if (r < 7)      m = 3'(1 << want);
      else if (r < 9) m = 3'(1 << $urandom_range(0, 2));
      else            m = 3'($urandom_range(1, 7));
      s = BW'($urandom);
      if ($urandom_range(0, 4) != 0) s[OW-1:0] = ops[$urandom_range(0, 7)];
      press(m, s, $urandom_range(0, 4));
      check_outputs("rand");
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
